// File: rtl/countdown_timer.sv
// Loadable down-counting timer with one-shot and periodic modes plus pause/resume.
// Latency: start at edge N shows count=R and busy=1 after that edge. With en held
// high in one-shot mode, done pulses for the one cycle after edge N+R.
// Backpressure: none. The en input gates each decrement, and stop freezes the count in HOLD.
module countdown_timer #(
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   load,
    input  logic [COUNT_WIDTH-1:0] load_val,
    input  logic                   mode,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   clear,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   busy,
    output logic                   running,
    output logic                   done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] ZERO = '0;
    localparam logic [COUNT_WIDTH-1:0] ONE  = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                 state;
    logic [COUNT_WIDTH-1:0] reload;
    logic [COUNT_WIDTH-1:0] eff_reload;

    // A load in the same cycle as a start or expiry takes effect at once.
    assign eff_reload = load ? load_val : reload;

    // Timer FSM. All outputs are registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            count   <= ZERO;
            reload  <= ZERO;
            busy    <= 1'b0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                reload <= load_val;
            end

            if (clear) begin
                // Abort. The reload register is kept so that a later start reuses it.
                state   <= IDLE;
                count   <= ZERO;
                busy    <= 1'b0;
                running <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (eff_reload != ZERO) begin
                                state   <= RUN;
                                count   <= eff_reload;
                                busy    <= 1'b1;
                                running <= 1'b1;
                            end else begin
                                // A zero-length timer expires immediately.
                                count <= ZERO;
                                done  <= 1'b1;
                            end
                        end
                    end

                    RUN: begin
                        if (stop) begin
                            state   <= HOLD;
                            running <= 1'b0;
                        end else if (start) begin
                            // A restart wins over an expiry on the same cycle, and no done pulse is produced.
                            if (eff_reload != ZERO) begin
                                count <= eff_reload;
                            end else begin
                                state   <= IDLE;
                                count   <= ZERO;
                                busy    <= 1'b0;
                                running <= 1'b0;
                            end
                        end else if (en) begin
                            if (count > ONE) begin
                                count <= count - ONE;
                            end else begin
                                done <= 1'b1;
                                if (mode && (eff_reload != ZERO)) begin
                                    count <= eff_reload;
                                end else begin
                                    state   <= IDLE;
                                    count   <= ZERO;
                                    busy    <= 1'b0;
                                    running <= 1'b0;
                                end
                            end
                        end
                    end

                    HOLD: begin
                        // Resume leaves the count unchanged. A simultaneous stop keeps the timer paused.
                        if (start && !stop) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end

                    default: begin
                        state   <= IDLE;
                        count   <= ZERO;
                        busy    <= 1'b0;
                        running <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer.
// Inputs are driven 1ns after the rising edge, and outputs are sampled at that same point.
// Each scenario task holds its own inline comparisons.
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       load;
    logic [7:0] load_val;
    logic       mode;
    logic       start;
    logic       stop;
    logic       clear;
    logic [7:0] count;
    logic       busy;
    logic       running;
    logic       done;

    int checks   = 0;
    int failures = 0;

    countdown_timer #(.COUNT_WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .mode     (mode),
        .start    (start),
        .stop     (stop),
        .clear    (clear),
        .count    (count),
        .busy     (busy),
        .running  (running),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        en = 1'b0; load = 1'b0; load_val = 8'd0; mode = 1'b0;
        start = 1'b0; stop = 1'b0; clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        checks++;
        if ({count, busy, running, done} !== 11'd0) begin
            failures++;
            $display("FAIL reset_state: count=%0d busy=%b running=%b done=%b, required all 0",
                     count, busy, running, done);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_one_shot();
        logic [7:0] exp_cnt [6] = '{8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
        logic       exp_dn  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic       exp_bsy [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        load = 1'b1; load_val = 8'd5; start = 1'b1; mode = 1'b0; en = 1'b1;
        tick();
        load = 1'b0; start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (count !== exp_cnt[i] || done !== exp_dn[i] || busy !== exp_bsy[i]) begin
                failures++;
                $display("FAIL one_shot[%0d]: count=%0d done=%b busy=%b, required count=%0d done=%b busy=%b",
                         i, count, done, busy, exp_cnt[i], exp_dn[i], exp_bsy[i]);
            end
            if (i < 5) tick();
        end
        tick();
        checks++;
        if (done !== 1'b0 || count !== 8'd0) begin
            failures++;
            $display("FAIL one_shot_after: done=%b count=%0d, required done=0 count=0", done, count);
        end
        idle_inputs();
    endtask

    task automatic test_periodic();
        logic [7:0] exp_cnt [9] = '{8'd2, 8'd1, 8'd3, 8'd2, 8'd1, 8'd3, 8'd2, 8'd1, 8'd3};
        logic       exp_dn  [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        load = 1'b1; load_val = 8'd3;
        tick();
        load = 1'b0; start = 1'b1; mode = 1'b1; en = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (count !== 8'd3 || busy !== 1'b1 || running !== 1'b1) begin
            failures++;
            $display("FAIL periodic_start: count=%0d busy=%b running=%b, required 3 1 1", count, busy, running);
        end
        for (int i = 0; i < 9; i++) begin
            tick();
            checks++;
            if (count !== exp_cnt[i] || done !== exp_dn[i] || busy !== 1'b1) begin
                failures++;
                $display("FAIL periodic[%0d]: count=%0d done=%b busy=%b, required count=%0d done=%b busy=1",
                         i, count, done, busy, exp_cnt[i], exp_dn[i]);
            end
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++;
        if (count !== 8'd0 || busy !== 1'b0 || running !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL periodic_clear: count=%0d busy=%b running=%b done=%b, required 0 0 0 0",
                     count, busy, running, done);
        end
        idle_inputs();
    endtask

    task automatic test_enable_hold();
        logic [7:0] exp_cnt [5] = '{8'd4, 8'd3, 8'd3, 8'd2, 8'd2};
        logic       en_seq  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        load = 1'b1; load_val = 8'd4; start = 1'b1; mode = 1'b0; en = 1'b0;
        tick();
        load = 1'b0; start = 1'b0;
        // exp_cnt[i] is the count before en_seq[i] is applied.
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (count !== exp_cnt[i]) begin
                failures++;
                $display("FAIL en_gate[%0d]: count=%0d, required %0d", i, count, exp_cnt[i]);
            end
            en = en_seq[i];
            tick();
        end
        stop = 1'b1; en = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if (count !== 8'd2 || busy !== 1'b1 || running !== 1'b0) begin
            failures++;
            $display("FAIL hold_enter: count=%0d busy=%b running=%b, required 2 1 0", count, busy, running);
        end
        repeat (5) tick();
        checks++;
        if (count !== 8'd2 || running !== 1'b0) begin
            failures++;
            $display("FAIL hold_frozen: count=%0d running=%b, required 2 0", count, running);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (count !== 8'd2 || running !== 1'b1) begin
            failures++;
            $display("FAIL resume: count=%0d running=%b, required 2 1", count, running);
        end
        tick();
        tick();
        checks++;
        if (count !== 8'd0 || done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL resume_done: count=%0d done=%b busy=%b, required 0 1 0", count, done, busy);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_zero_reload();
        load = 1'b1; load_val = 8'd0;
        tick();
        load = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || count !== 8'd0) begin
            failures++;
            $display("FAIL zero_start: done=%b busy=%b count=%0d, required 1 0 0", done, busy, count);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_after: done=%b busy=%b, required 0 0", done, busy);
        end
    endtask

    task automatic test_back_to_back();
        load = 1'b1; load_val = 8'd2; start = 1'b1; mode = 1'b1; en = 1'b1;
        tick();
        load = 1'b0; start = 1'b0;
        tick();
        checks++;
        if (count !== 8'd1) begin
            failures++;
            $display("FAIL b2b_setup: count=%0d, required 1", count);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (count !== 8'd2 || done !== 1'b0) begin
            failures++;
            $display("FAIL restart_on_expiry: count=%0d done=%b, required 2 0", count, done);
        end
        load = 1'b1; load_val = 8'd9;
        tick();
        load = 1'b0;
        checks++;
        if (count !== 8'd1) begin
            failures++;
            $display("FAIL load_in_run: count=%0d, required 1", count);
        end
        tick();
        checks++;
        if (count !== 8'd9 || done !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL new_reload: count=%0d done=%b busy=%b, required 9 1 1", count, done, busy);
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        load = 1'b1; load_val = 8'd9; start = 1'b1; mode = 1'b0; en = 1'b1;
        tick();
        load = 1'b0; start = 1'b0;
        tick();
        tick();
        checks++;
        if (count !== 8'd7) begin
            failures++;
            $display("FAIL arst_setup: count=%0d, required 7", count);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({count, busy, running, done} !== 11'd0) begin
            failures++;
            $display("FAIL arst_immediate: count=%0d busy=%b running=%b done=%b, required all 0",
                     count, busy, running, done);
        end
        #2 rst = 1'b0;
        idle_inputs();
        tick();
        checks++;
        if (done !== 1'b0 || count !== 8'd0) begin
            failures++;
            $display("FAIL arst_no_done: done=%b count=%0d, required 0 0", done, count);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || count !== 8'd0) begin
            failures++;
            $display("FAIL arst_zero_timer: done=%b busy=%b count=%0d, required 1 0 0", done, busy, count);
        end
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_periodic();
        test_enable_hold();
        test_zero_reload();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
